// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed 7-segment (FND) scan controller: latches a 0-9999 count,
// converts it to BCD and time-multiplexes the digits with active-low com/segment drives.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100_000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] count,
  input  logic        count_valid,
  output logic [7:0]  fnd_data,
  output logic [3:0]  fnd_com
);

  localparam int              PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [13:0]     VALUE_MAX  = 14'd9999;
  localparam logic [7:0]      SEG_BLANK  = 8'hFF;

  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    idx;
  logic [13:0]   value;
  logic [15:0]   bcd;
  logic [3:0]    digit;
  logic          blank;
  logic [3:0]    com_next;
  logic [7:0]    data_next;

  // Shift-and-add-3 conversion; value is already clamped so four digits suffice.
  function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (sh[14+4*j +: 4] >= 4'd5) begin
          sh[14+4*j +: 4] = sh[14+4*j +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Clamp at capture time so every downstream stage only ever sees 0..9999.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= 14'd0;
    end else if (count_valid) begin
      value <= (count > VALUE_MAX) ? VALUE_MAX : count;
    end
  end

  assign bcd = bin_to_bcd(value);

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (idx)
      2'd0: begin
        digit = bcd[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        digit = bcd[7:4];
        blank = (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        digit = bcd[11:8];
        blank = (bcd[15:8] == 8'd0);
      end
      default: begin
        digit = bcd[15:12];
        blank = (bcd[15:12] == 4'd0);
      end
    endcase
    if (!LZ_BLANK) begin
      blank = 1'b0;
    end
  end

  always_comb begin
    com_next  = ~(4'b0001 << idx);
    data_next = blank ? SEG_BLANK : seg_encode(digit);
  end

  // Registered drives: one cycle behind idx/value, all digits dark in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fnd_com  <= 4'b1111;
      fnd_data <= SEG_BLANK;
    end else begin
      fnd_com  <= com_next;
      fnd_data <= data_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller (SCAN_DIV=4): blanking and non-blanking instances share
// stimulus; a cycle-indexed monitor checks every output cycle against queued expectations.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;
  localparam int W        = 96;
  localparam logic [31:0] ZERO_LZ  = 32'hFF_FF_FF_C0;
  localparam logic [31:0] ZERO_NLZ = 32'hC0_C0_C0_C0;

  logic        clk;
  logic        reset;
  logic [13:0] count;
  logic        count_valid;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data_nlz;
  logic [3:0]  fnd_com_nlz;

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(reset), .count(count), .count_valid(count_valid),
    .fnd_data(fnd_data), .fnd_com(fnd_com)
  );

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b0)) dut_nlz (
    .clk(clk), .reset(reset), .count(count), .count_valid(count_valid),
    .fnd_data(fnd_data_nlz), .fnd_com(fnd_com_nlz)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry: {cycle from which the value is visible, blanked codes, unblanked codes};
  // codes are packed {thousands, hundreds, tens, ones}.
  logic [W-1:0] exp_q[$];
  logic [31:0]  cur_lz;
  logic [31:0]  cur_nlz;
  int           n_vec;
  int           n_err;
  bit           mon_en;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  initial begin
    logic [W-1:0] ent;
    int           dig;
    logic [3:0]   exp_com;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_lz  = ZERO_LZ;
        cur_nlz = ZERO_NLZ;
        exp_q.delete();
      end else if (mon_en && cyc >= 1) begin
        while (exp_q.size() > 0 && exp_q[0][95:64] <= 32'(cyc)) begin
          ent     = exp_q.pop_front();
          cur_lz  = ent[63:32];
          cur_nlz = ent[31:0];
        end
        dig     = ((cyc - 1) / SCAN_DIV) % 4;
        exp_com = ~(4'b0001 << dig);
        check("mon_com_lz",   {4'h0, fnd_com},     {4'h0, exp_com});
        check("mon_data_lz",  fnd_data,            cur_lz[dig*8 +: 8]);
        check("mon_com_nlz",  {4'h0, fnd_com_nlz}, {4'h0, exp_com});
        check("mon_data_nlz", fnd_data_nlz,        cur_nlz[dig*8 +: 8]);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge: latched on the next edge, shown after the one after.
  task automatic load(input logic [13:0] c, input logic [31:0] lz, input logic [31:0] nlz);
    count       = c;
    count_valid = 1'b1;
    exp_q.push_back({32'(cyc + 2), lz, nlz});
    @(negedge clk);
    count_valid = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [13:0] cnt;
    logic [31:0] lz;
    logic [31:0] nlz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k;
    int d;
    vecs[0] = '{14'd1234,  32'hF9_A4_B0_99, 32'hF9_A4_B0_99};
    vecs[1] = '{14'd7,     32'hFF_FF_FF_F8, 32'hC0_C0_C0_F8};
    vecs[2] = '{14'd12000, 32'h90_90_90_90, 32'h90_90_90_90};
    vecs[3] = '{14'd0,     32'hFF_FF_FF_C0, 32'hC0_C0_C0_C0};
    vecs[4] = '{14'd9999,  32'h90_90_90_90, 32'h90_90_90_90};
    vecs[5] = '{14'd10000, 32'h90_90_90_90, 32'h90_90_90_90};
    vecs[6] = '{14'd16383, 32'h90_90_90_90, 32'h90_90_90_90};
    vecs[7] = '{14'd50,    32'hFF_FF_92_C0, 32'hC0_C0_92_C0};
    vecs[8] = '{14'd1005,  32'hF9_C0_C0_92, 32'hF9_C0_C0_92};
    vecs[9] = '{14'd386,   32'hFF_B0_80_82, 32'hC0_B0_80_82};

    n_vec       = 0;
    n_err       = 0;
    mon_en      = 1'b1;
    count       = 14'd0;
    count_valid = 1'b0;
    cur_lz      = ZERO_LZ;
    cur_nlz     = ZERO_NLZ;

    // Power-on reset: low for 20 ns.
    reset = 1'b1;
    #2 reset = 1'b0;
    #8;
    check("rst_com",      {4'h0, fnd_com},     8'h0F);
    check("rst_data",     fnd_data,            8'hFF);
    check("rst_com_nlz",  {4'h0, fnd_com_nlz}, 8'h0F);
    check("rst_data_nlz", fnd_data_nlz,        8'hFF);
    #12 reset = 1'b1;
    @(negedge clk);
    check("post_rst_com",  {4'h0, fnd_com}, 8'h0E);
    check("post_rst_data", fnd_data,        8'hC0);
    repeat (17) @(negedge clk);

    // Table: each value held for a full refresh plus the load latency.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      load(vecs[i].cnt, vecs[i].lz, vecs[i].nlz);
      repeat (4 * SCAN_DIV + 2) @(negedge clk);
    end

    // count_valid on the same edge as a tick: new value and new digit together.
    load(vecs[0].cnt, vecs[0].lz, vecs[0].nlz);
    repeat (4 * SCAN_DIV + 2) @(negedge clk);
    for (int i = 0; i < 8 && (cyc % SCAN_DIV) != SCAN_DIV - 1; i++) @(negedge clk);
    k = cyc;
    d = ((k - 1) / SCAN_DIV) % 4;
    load(vecs[1].cnt, vecs[1].lz, vecs[1].nlz);
    check("tick_pre_com",  {4'h0, fnd_com}, {4'h0, ~(4'b0001 << d)});
    check("tick_pre_data", fnd_data,        vecs[0].lz[d*8 +: 8]);
    @(negedge clk);
    check("tick_post_com",  {4'h0, fnd_com}, {4'h0, ~(4'b0001 << ((d + 1) % 4))});
    check("tick_post_data", fnd_data,        vecs[1].lz[((d + 1) % 4)*8 +: 8]);
    repeat (4 * SCAN_DIV) @(negedge clk);

    // Unstrobed input changes must not reach the display.
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      count = 14'($urandom_range(1, 9999));
      @(negedge clk);
    end
    repeat (4 * SCAN_DIV) @(negedge clk);

    // Reset mid-refresh while 1234 is shown: immediate blank, then 0 until reloaded.
    load(vecs[0].cnt, vecs[0].lz, vecs[0].nlz);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_com",      {4'h0, fnd_com},     8'h0F);
    check("midrst_data",     fnd_data,            8'hFF);
    check("midrst_com_nlz",  {4'h0, fnd_com_nlz}, 8'h0F);
    check("midrst_data_nlz", fnd_data_nlz,        8'hFF);
    repeat (2) @(negedge clk);
    check("midrst_hold_com",  {4'h0, fnd_com}, 8'h0F);
    check("midrst_hold_data", fnd_data,        8'hFF);
    reset = 1'b1;
    @(negedge clk);
    check("rerst_com",  {4'h0, fnd_com}, 8'h0E);
    check("rerst_data", fnd_data,        8'hC0);
    repeat (4 * SCAN_DIV + 2) @(negedge clk);

    load(vecs[7].cnt, vecs[7].lz, vecs[7].nlz);
    repeat (4 * SCAN_DIV + 2) @(negedge clk);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
